// File: rtl/cmos_pixel_capture.sv
// -----------------------------------------------------------------------------
// cmos_pixel_capture
//
// Capture front end for an OV7670-style camera. Samples VSYNC/HREF/D[7:0] on
// the camera pixel clock, pairs RGB565 bytes into RGB444 pixels, decimates
// the image by 2^DECIMATE_LOG2 in both axes and emits one registered write
// strobe per kept pixel with a linear frame-buffer address.
//
// Ports:
//   clk_i              camera pixel clock, all logic on the rising edge
//   reset_i            asynchronous active-low reset
//   vsync_cmos_i       camera VSYNC, high between frames
//   href_cmos_i        camera HREF, high during active line bytes
//   pixel_data_cmos_i  camera byte
//   wr_en_o            one-cycle write strobe
//   wr_addr_o          frame-buffer write address
//   wr_data_o          pixel {R[3:0],G[3:0],B[3:0]}
//   frame_done_o       one-cycle pulse at the end of each captured frame
//   frame_count_o      completed frames, wraps 255->0
//   line_error_o       sticky per frame: odd byte count or wrong line length
//   overflow_o         sticky per frame: write attempted at addr >= BUF_DEPTH
// -----------------------------------------------------------------------------
module cmos_pixel_capture #(
    parameter int SRC_COLUMNS   = 640,
    parameter int SRC_ROWS      = 480,
    parameter int DECIMATE_LOG2 = 1,
    parameter int BUF_DEPTH     = (SRC_COLUMNS * SRC_ROWS) >> (2 * DECIMATE_LOG2),
    parameter int ADDR_WIDTH    = $clog2(BUF_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  vsync_cmos_i,
    input  logic                  href_cmos_i,
    input  logic [7:0]            pixel_data_cmos_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [11:0]           wr_data_o,
    output logic                  frame_done_o,
    output logic [7:0]            frame_count_o,
    output logic                  line_error_o,
    output logic                  overflow_o
);

    localparam logic [1:0] ST_SYNC       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_ACTIVE     = 2'd2;

    // Counters are one value wider than the limit so they can sit at the
    // limit (saturated) without wrapping back into the valid range.
    localparam int COL_W = $clog2(SRC_COLUMNS + 1);
    localparam int ROW_W = $clog2(SRC_ROWS + 1);
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [COL_W-1:0] COLS_L = COL_W'(SRC_COLUMNS);
    localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(SRC_ROWS);
    localparam logic [CNT_W-1:0] BUF_L  = CNT_W'(BUF_DEPTH);

    logic [1:0]       state_reg;
    logic             vsync_reg;
    logic             vsync_prev_reg;
    logic             href_reg;
    logic             href_prev_reg;
    logic [7:0]       data_reg;
    logic [6:0]       b1_reg;       // {b1[7:4], b1[2:0]}; b1[3] is never used
    logic             phase_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic [CNT_W-1:0] addr_reg;

    logic        vsync_rise;
    logic        vsync_fall;
    logic        href_fall;
    logic        in_window;
    logic        keep;
    logic [11:0] pixel_rgb;

    assign vsync_rise = vsync_reg & ~vsync_prev_reg;
    assign vsync_fall = ~vsync_reg & vsync_prev_reg;
    assign href_fall  = ~href_reg & href_prev_reg;
    assign in_window  = (col_reg < COLS_L) && (row_reg < ROWS_L);
    assign pixel_rgb  = {b1_reg[6:3], b1_reg[2:0], data_reg[7], data_reg[4:1]};

    generate
        if (DECIMATE_LOG2 == 0) begin : g_keep_all
            assign keep = 1'b1;
        end else begin : g_keep_decim
            assign keep = (col_reg[DECIMATE_LOG2-1:0] == '0) &&
                          (row_reg[DECIMATE_LOG2-1:0] == '0);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg      <= ST_SYNC;
            vsync_reg      <= 1'b0;
            vsync_prev_reg <= 1'b0;
            href_reg       <= 1'b0;
            href_prev_reg  <= 1'b0;
            data_reg       <= '0;
            b1_reg         <= '0;
            phase_reg      <= 1'b0;
            col_reg        <= '0;
            row_reg        <= '0;
            addr_reg       <= '0;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            frame_done_o   <= 1'b0;
            frame_count_o  <= '0;
            line_error_o   <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            vsync_reg      <= vsync_cmos_i;
            vsync_prev_reg <= vsync_reg;
            href_reg       <= href_cmos_i;
            href_prev_reg  <= href_reg;
            data_reg       <= pixel_data_cmos_i;
            wr_en_o        <= 1'b0;
            frame_done_o   <= 1'b0;

            case (state_reg)
                ST_SYNC: begin
                    // Only a full VSYNC pulse proves we are at a frame boundary.
                    if (vsync_rise) begin
                        state_reg <= ST_WAIT_FRAME;
                    end
                end

                ST_WAIT_FRAME: begin
                    if (vsync_fall) begin
                        state_reg    <= ST_ACTIVE;
                        addr_reg     <= '0;
                        col_reg      <= '0;
                        row_reg      <= '0;
                        phase_reg    <= 1'b0;
                        line_error_o <= 1'b0;
                        overflow_o   <= 1'b0;
                    end
                end

                ST_ACTIVE: begin
                    // A byte arriving with the frame-ending VSYNC edge is
                    // dropped; clearing phase discards any half pixel.
                    if (href_reg && !vsync_rise) begin
                        phase_reg <= ~phase_reg;
                        if (!phase_reg) begin
                            b1_reg <= {data_reg[7:4], data_reg[2:0]};
                        end else begin
                            if (col_reg < COLS_L) begin
                                col_reg <= col_reg + 1'b1;
                            end else begin
                                line_error_o <= 1'b1;
                            end
                            if (in_window && keep) begin
                                if (addr_reg < BUF_L) begin
                                    wr_en_o   <= 1'b1;
                                    wr_addr_o <= addr_reg[ADDR_WIDTH-1:0];
                                    wr_data_o <= pixel_rgb;
                                    addr_reg  <= addr_reg + 1'b1;
                                end else begin
                                    overflow_o <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        phase_reg <= 1'b0;
                    end

                    // Line check runs before the frame end in the same cycle;
                    // the two touch disjoint state so ordering is free.
                    if (href_fall) begin
                        if (phase_reg || (col_reg != COLS_L)) begin
                            line_error_o <= 1'b1;
                        end
                        col_reg <= '0;
                        if (row_reg < ROWS_L) begin
                            row_reg <= row_reg + 1'b1;
                        end
                    end

                    if (vsync_rise) begin
                        state_reg     <= ST_WAIT_FRAME;
                        frame_done_o  <= 1'b1;
                        frame_count_o <= frame_count_o + 8'd1;
                    end
                end

                default: begin
                    state_reg <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
